mac_accum4: RTL and testbench
=============================

Name: mac_accum4

Overview:
Downstream consumer of the 4x4 unsigned array multiplier's 8-bit product.
- Accumulates a programmed number of product beats into a wide saturating accumulator.
- Presents the dot-product result on a valid/ready output port.
- Sequences one vector per start pulse: multiplier output → mac_accum4 → result sink.

Parameters:
ACC_W, 16, accumulator and result width; legal range 9..32.
LEN_W, 4, width of the vector-length field; max vector length is 2^LEN_W-1.
SAT_EN, 1, 1 = clamp at 2^ACC_W-1 with sticky overflow flag; 0 = modulo-2^ACC_W wrap (ovf still flags wrap).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to begin a vector; sampled only in IDLE.
len  input  LEN_W  number of product beats; sampled with start.
prod  input  8  unsigned product from the multiplier stage.
in_valid  input  1  prod is valid this cycle.
in_ready  output  1  block accepts prod this cycle.
acc_out  output  ACC_W  accumulated result.
ovf  output  1  overflow occurred during this vector.
out_valid  output  1  acc_out/ovf valid.
out_ready  input  1  sink accepts the result.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous and active-low; assertion takes effect immediately, release is synchronous to clk.
- Reset values: state=IDLE, acc_out=0, ovf=0, out_valid=0, in_ready=0, busy=0, remaining count=0.
- Reset mid-operation: the vector is abandoned. No result is produced and no partial state survives.
- Handshakes:
  - A beat transfers when in_valid & in_ready at a rising edge.
  - A result transfers when out_valid & out_ready at a rising edge.
  - prod is not registered before the add; it is added combinationally in the accepting cycle.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 and len!=0 → ACCUM. On that edge: acc cleared to 0, ovf cleared, remaining=len.
  - start=1 and len==0 → DONE. On that edge: acc=0, ovf=0. This is an empty vector and produces a result of 0.
- ACCUM:
  - in_ready=1 continuously.
  - Each accepted beat: acc ← acc + zero-extended prod, remaining ← remaining-1.
  - in_valid gaps are allowed; state and acc hold through them.
  - Accepting the beat with remaining==1 → DONE.
  - start is ignored.
- DONE:
  - out_valid=1, in_ready=0. acc_out and ovf stay stable while out_ready=0.
  - out_valid & out_ready → IDLE.
  - start asserted in the same cycle as the DONE→IDLE transfer is ignored. The new vector needs start in IDLE.
- Latency: out_valid rises on the edge that accepts the last beat. It is visible the cycle after the last beat was presented.
- Minimum throughput per vector: len+2 cycles (start edge, len beats, one drain cycle with out_ready=1).
- Arithmetic:
  - Unsigned only. The sum is computed at ACC_W+1 bits.
  - If the carry-out is set, ovf ← 1. ovf is sticky until the next start.
  - SAT_EN=1: acc ← 2^ACC_W-1, and it stays there for the rest of the vector; every later add also saturates.
  - SAT_EN=0: acc ← low ACC_W bits of the sum.
- Defaults: with ACC_W=16 and LEN_W=4, the max sum is 15*225 = 3375, so no overflow is possible. Overflow is reachable only at small ACC_W.

Decomposition:
- Package mac_pkg holds:
  - the state enum {IDLE, ACCUM, DONE};
  - the default ACC_W and LEN_W constants;
  - the product width constant PROD_W=8.
- One sub-module, sat_add: parameterised ACC_W, with an ACC_W-bit unsigned input plus a PROD_W-bit unsigned input. It outputs the sum and a carry/ovf flag, and is combinational with a SAT_EN parameter.
- The FSM, counter and registers stay in mac_accum4.

Test Plan:
1. Basic vector: reset; start with len=3; beats prod=225,225,225 back-to-back with out_ready=1 → in_ready high for 3 cycles, out_valid one cycle, acc_out=675 (0x02A3), ovf=0, then busy=0.
2. Gaps and backpressure: len=2; prod=6, then 2 idle cycles, then prod=9; hold out_ready=0 for 4 cycles → acc_out=15 held stable with out_valid=1 for all 4 cycles; transfer on out_ready=1; return to IDLE.
3. Saturation: ACC_W=10, SAT_EN=1; len=5; prod=225 x5 → after beat 5 the sum is 1125 > 1023, so acc_out=1023 and ovf=1. With SAT_EN=0 the same stimulus gives acc_out=101 and ovf=1.
4. Empty vector and ignored start: start with len=0 → out_valid the next cycle, acc_out=0, ovf=0. A start pulse during ACCUM with len=3 does not restart the count or clear acc.
5. Reset mid-operation: len=4; accept prod=100,100; assert rst_n=0 asynchronously between edges → all outputs are 0 immediately. After release, a new start with len=1 and prod=7 → acc_out=7.
6. Max length: len=15 with all beats prod=0xFF (255) → acc_out=3825 (0x0EF1), ovf=0, exactly 15 accepted beats.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and constants for the product accumulator.
package mac_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  localparam int unsigned ACC_W_DEFAULT = 16;
  localparam int unsigned LEN_W_DEFAULT = 4;
  localparam int unsigned PROD_W        = 8;

endpackage

// File: rtl/sat_add.sv
// Combinational ACC_W + PROD_W unsigned adder with carry-out flag and optional clamp.
module sat_add
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W  = ACC_W_DEFAULT,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W:0] sum_wide;

  always_comb begin
    sum_wide = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
    ovf      = sum_wide[ACC_W];
    // Clamp on carry; otherwise keep the low bits (modulo wrap).
    if (SAT_EN && sum_wide[ACC_W]) begin
      sum = '1;
    end else begin
      sum = sum_wide[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/mac_accum4.sv
// Accumulates a programmed number of 8-bit product beats and presents the sum on a
// valid/ready result port.
module mac_accum4
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W  = ACC_W_DEFAULT,
  parameter int unsigned LEN_W  = LEN_W_DEFAULT,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [PROD_W-1:0] prod,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;

  sat_add #(
    .ACC_W  (ACC_W),
    .SAT_EN (SAT_EN)
  ) u_sat_add (
    .a   (acc_q),
    .b   (prod),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          rem_d   = len;
          // An empty vector goes straight to DONE with a zero result.
          state_d = (len == '0) ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (in_valid) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_ovf;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != StIdle);
    acc_out   = acc_q;
    ovf       = ovf_q;
    unique case (state_q)
      StAccum: in_ready  = 1'b1;
      StDone:  out_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mac_accum4.sv
// Self-checking bench: three accumulator configurations share stimulus and are compared
// against a sum-of-beats reference model every cycle.
module tb_mac_accum4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] len = '0;
  logic [7:0] prod = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic [15:0] acc0;
  logic [9:0]  acc1, acc2;
  logic [2:0]  in_ready_w, ovf_w, out_valid_w, busy_w;

  int n_err = 0;
  int n_chk = 0;
  int n_beats = 0;

  // Reference model: protocol phase plus the unbounded running total of the vector.
  int     m_phase = 0;  // 0 idle, 1 collecting beats, 2 result pending
  int     m_rem = 0;
  longint m_total = 0;

  always #5 clk = ~clk;

  mac_accum4 #(.ACC_W(16), .LEN_W(4), .SAT_EN(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
    .in_valid(in_valid), .in_ready(in_ready_w[0]), .acc_out(acc0), .ovf(ovf_w[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .busy(busy_w[0])
  );

  mac_accum4 #(.ACC_W(10), .LEN_W(4), .SAT_EN(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
    .in_valid(in_valid), .in_ready(in_ready_w[1]), .acc_out(acc1), .ovf(ovf_w[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .busy(busy_w[1])
  );

  mac_accum4 #(.ACC_W(10), .LEN_W(4), .SAT_EN(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
    .in_valid(in_valid), .in_ready(in_ready_w[2]), .acc_out(acc2), .ovf(ovf_w[2]),
    .out_valid(out_valid_w[2]), .out_ready(out_ready), .busy(busy_w[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_acc(input int w, input bit sat, input longint total);
    longint lim = (longint'(1) << w) - 1;
    if (total <= lim) return 32'(total);
    return sat ? 32'(lim) : 32'(total % (longint'(1) << w));
  endfunction

  task automatic check_all();
    logic [2:0] rdy_e, vld_e, bsy_e;
    rdy_e = {3{m_phase == 1}};
    vld_e = {3{m_phase == 2}};
    bsy_e = {3{m_phase != 0}};
    chk("in_ready", 32'(in_ready_w), 32'(rdy_e));
    chk("out_valid", 32'(out_valid_w), 32'(vld_e));
    chk("busy", 32'(busy_w), 32'(bsy_e));
    chk("acc16_sat", 32'(acc0), exp_acc(16, 1'b1, m_total));
    chk("acc10_sat", 32'(acc1), exp_acc(10, 1'b1, m_total));
    chk("acc10_wrap", 32'(acc2), exp_acc(10, 1'b0, m_total));
    chk("ovf16", 32'(ovf_w[0]), 32'(m_total > 65535));
    chk("ovf10", 32'({ovf_w[2], ovf_w[1]}), (m_total > 1023) ? 32'd3 : 32'd0);
  endtask

  // Advance one clock: update the model from the presented inputs, then check after the edge.
  task automatic tick();
    if (in_ready_w[0] && in_valid) n_beats++;
    case (m_phase)
      0: if (start) begin
        m_total = 0;
        m_rem   = int'(len);
        m_phase = (len == 0) ? 2 : 1;
      end
      1: if (in_valid) begin
        m_total += longint'(prod);
        m_rem--;
        if (m_rem == 0) m_phase = 2;
      end
      default: if (out_ready) m_phase = 0;
    endcase
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    start = 1'b0; len = '0; prod = '0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic begin_vector(input logic [3:0] l);
    start = 1'b1; len = l; tick(); start = 1'b0; len = '0;
  endtask

  task automatic beat(input logic [7:0] p);
    in_valid = 1'b1; prod = p; tick(); in_valid = 1'b0;
  endtask

  initial begin
    // Power-on reset, released away from the clock edge.
    #12;
    chk("rst_acc", 32'(acc0), 32'd0);
    chk("rst_flags", 32'({in_ready_w, out_valid_w, busy_w, ovf_w}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_all();

    // 1: basic vector, len=3 of 225.
    begin_vector(4'd3);
    beat(8'd225); beat(8'd225); beat(8'd225);
    chk("t1_acc", 32'(acc0), 32'd675);
    chk("t1_valid", 32'(out_valid_w[0]), 32'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t1_busy", 32'(busy_w[0]), 32'd0);

    // 2: gaps and backpressure.
    begin_vector(4'd2);
    beat(8'd6); tick(); tick(); beat(8'd9);
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_acc", 32'(acc0), 32'd15);
      chk("t2_hold_valid", 32'(out_valid_w[0]), 32'd1);
      tick();
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t2_idle", 32'(busy_w[0]), 32'd0);

    // 3: overflow in the 10-bit instances, both policies.
    begin_vector(4'd5);
    for (int i = 0; i < 5; i++) beat(8'd225);
    chk("t3_sat", 32'(acc1), 32'd1023);
    chk("t3_wrap", 32'(acc2), 32'd101);
    chk("t3_ovf", 32'({ovf_w[2], ovf_w[1], ovf_w[0]}), 32'b110);
    chk("t3_wide", 32'(acc0), 32'd1125);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // 4: empty vector, then a start during accumulation that must be ignored.
    begin_vector(4'd0);
    chk("t4_empty_valid", 32'(out_valid_w[0]), 32'd1);
    chk("t4_empty_acc", 32'(acc0), 32'd0);
    out_ready = 1'b1; start = 1'b1; len = 4'd2; tick();
    out_ready = 1'b0; start = 1'b0;
    chk("t4_start_on_drain", 32'(busy_w[0]), 32'd0);
    begin_vector(4'd3);
    beat(8'd10);
    start = 1'b1; len = 4'd3; beat(8'd20); start = 1'b0;
    beat(8'd30);
    chk("t4_no_restart", 32'(acc0), 32'd60);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // 5: asynchronous reset mid-vector.
    begin_vector(4'd4);
    beat(8'd100); beat(8'd100);
    #3 rst_n = 1'b0;
    #1;
    m_phase = 0; m_total = 0; m_rem = 0;
    chk("t5_rst_acc", 32'(acc0), 32'd0);
    chk("t5_rst_flags", 32'({in_ready_w, out_valid_w, busy_w, ovf_w}), 32'd0);
    idle_inputs();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_all();
    begin_vector(4'd1);
    beat(8'd7);
    chk("t5_after_rst", 32'(acc0), 32'd7);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // 6: maximum length of 0xFF beats.
    n_beats = 0;
    begin_vector(4'd15);
    in_valid = 1'b1; prod = 8'hFF;
    for (int i = 0; i < 18 && m_phase == 1; i++) tick();
    in_valid = 1'b0;
    chk("t6_acc", 32'(acc0), 32'd3825);
    chk("t6_ovf", 32'(ovf_w[0]), 32'd0);
    chk("t6_beats", 32'(n_beats), 32'd15);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Randomized vectors with gaps, backpressure and stray start pulses.
    for (int v = 0; v < 30; v++) begin
      begin_vector(4'($urandom_range(0, 15)));
      for (int c = 0; c < 300 && m_phase != 0; c++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        prod      = 8'($urandom);
        out_ready = ($urandom_range(0, 1) == 1);
        start     = ($urandom_range(0, 7) == 0);
        len       = 4'($urandom);
        tick();
      end
      idle_inputs();
      chk("rand_drained", 32'(busy_w[0]), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
